song_sequencer: RTL and testbench
=================================

# song_sequencer

Game-flow controller for the score/display path. It owns the start/pause/stop state machine and re-initialises the musical score loader at song start. It generates the beat tick that advances the note window and scores the player's detected note against the note at the hit line. It sits between the user-input debouncers, the pitch detector, the score loader and the video overlay.

## Interface
- COUNTIN_BEATS, 16: beats emitted before scoring begins, so the 16-note window fills.
- SONG_LEN, 128: maximum scored beats; matches the 7-bit loader address space.
- END_NOTE, 4'hF: note code that terminates a song.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begin a song.
- pause  in  1  one-cycle pulse; toggle pause.
- stop  in  1  one-cycle pulse; abort to idle.
- song_sel  in  1  song choice; sampled only at start.
- tempo  in  26  beat period in clk cycles, from the loader's tempo output.
- hit_note  in  4  note at the hit line, bits [3:0] of the loader's next-notes bus.
- player_note  in  4  note reported by the pitch detector.
- player_valid  in  1  player_note is valid this cycle.
- loader_reset  out  1  reset to the score loader.
- song_id  out  1  latched song selection.
- beat  out  1  one-cycle advance pulse to the loader/display.
- playing  out  1  high in COUNTIN or PLAY.
- paused  out  1  high in PAUSE.
- done  out  1  high in DONE.
- beat_index  out  8  scored beats elapsed in the current song.
- score  out  16  count of correct notes.
- streak  out  8  current run of consecutive correct notes.

## Operation
- States:
  - IDLE: waits for start.
  - LOAD: lasts 2 cycles.
  - COUNTIN
  - PLAY
  - PAUSE: holds a return-state register that records COUNTIN or PLAY.
  - DONE
- Input priority, highest first: reset, stop, pause, beat event, start.
- IDLE / DONE:
  - start moves to LOAD.
  - On that transition, song_id latches song_sel and score, streak, beat_index and the count-in counter clear.
- LOAD:
  - loader_reset is high for both cycles.
  - Then goes to COUNTIN.
  - tempo is latched into tempo_q on the first COUNTIN cycle.
- Beat timer:
  - A 26-bit counter runs only in COUNTIN and PLAY.
  - A beat event occurs when the counter equals max(tempo_q,1)-1; the counter then returns to 0.
  - The counter starts from 0 on COUNTIN entry.
- COUNTIN:
  - Each beat event pulses beat; no scoring is done.
  - After COUNTIN_BEATS beat events, moves to PLAY.
- PLAY, on each beat event:
  - beat pulses.
  - If hit_note==END_NOTE, or beat_index==SONG_LEN-1, moves to DONE. No scoring is done on the END_NOTE beat.
  - Otherwise, if hit_note==0 (rest), no scoring.
  - Otherwise, if player_valid && player_note==hit_note: score+1, saturating at 16'hFFFF; streak+1, saturating at 8'hFF.
  - Otherwise, streak clears to 0.
  - beat_index+1 on every PLAY beat event that does not terminate.
- pause:
  - From COUNTIN or PLAY, goes to PAUSE and records the return state.
  - From PAUSE, returns to the recorded state.
  - Ignored in IDLE, LOAD and DONE.
- PAUSE: the beat counter, score, streak and beat_index are all frozen.
- stop:
  - From LOAD, COUNTIN, PLAY, PAUSE or DONE, goes to IDLE.
  - score, streak and beat_index are held, not cleared.
- start is ignored outside IDLE and DONE.

## Timing
- During reset and the cycle after:
  - loader_reset=1 (it is the OR of reset and the LOAD state).
  - All other outputs are 0; state is IDLE.
- Latency:
  - start sampled in cycle n: loader_reset is high in n+1 and n+2; COUNTIN in n+3.
  - First beat pulse in cycle n+3+max(tempo,1).
- beat is a registered output: it is high for exactly one cycle, the cycle after the counter match.
- Scoring uses hit_note, player_note and player_valid sampled in the counter-match cycle. This is before the loader shifts on that beat.
- pause and a beat event in the same cycle:
  - pause wins and no beat is emitted.
  - The counter stays at its match value, so the beat fires on the first cycle after resume.
- stop and a beat event in the same cycle: stop wins; no beat, no scoring.
- Mid-operation reset: immediately goes to IDLE with all outputs cleared, overriding every other input.
- The tempo input is ignored after latching; a new tempo takes effect only at the next start.

## Test plan
- Basic start:
  - Stimulus: reset, then COUNTIN_BEATS=2, tempo=4, start at cycle 10.
  - Required: loader_reset high in cycles 11–12; beat pulses at cycles 17 and 21; PLAY begins after the second beat.
- Scoring:
  - Stimulus: in PLAY, hit_note=5 over 3 beats with player_note=5, 5, 3 (player_valid=1).
  - Required: score goes 1, 2, 2; streak goes 1, 2, 0. A rest (hit_note=0) leaves both unchanged.
- Pause:
  - Stimulus: pause in the same cycle as a counter match; wait 20 cycles; pause again.
  - Required: paused=1 and no beat while paused; beat on the first cycle after resume; score unchanged across the pause.
- End of song:
  - Stimulus: hit_note=4'hF at a PLAY beat.
  - Required: DONE next cycle with done=1, playing=0; score unchanged on that beat.
  - Stimulus: a second start.
  - Required: score clears; loader_reset pulses; song_id follows the new song_sel.
- SONG_LEN limit:
  - Stimulus: SONG_LEN=4, no END_NOTE in the song.
  - Required: DONE after the beat with beat_index=3.
- Stop:
  - Stimulus: stop in PAUSE.
  - Required: IDLE; score held.
  - Stimulus: then reset.
  - Required: score=0, song_id=0.

Source files
------------

// File: rtl/song_sequencer.sv
// song_sequencer: start/pause/stop game-flow FSM, beat timer and note scoring.
// Latency: start in cycle n -> loader_reset n+1..n+2, COUNTIN n+3, first beat n+3+max(tempo,1).
// Backpressure: none; pause freezes the beat timer and all scoring state.
// Ports: i_start/i_pause/i_stop one-cycle controls, i_song_sel sampled at start,
//   i_tempo beat period (latched on the first count-in cycle), i_hit_note/i_player_note/
//   i_player_valid scored at each PLAY beat; o_loader_reset, o_song_id, o_beat pulse,
//   o_playing/o_paused/o_done status, o_beat_index, o_score, o_streak.
module song_sequencer #(
   parameter int         COUNTIN_BEATS = 16,
   parameter int         SONG_LEN      = 128,
   parameter logic [3:0] END_NOTE      = 4'hF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_pause,
   input  logic        i_stop,
   input  logic        i_song_sel,
   input  logic [25:0] i_tempo,
   input  logic [3:0]  i_hit_note,
   input  logic [3:0]  i_player_note,
   input  logic        i_player_valid,
   output logic        o_loader_reset,
   output logic        o_song_id,
   output logic        o_beat,
   output logic        o_playing,
   output logic        o_paused,
   output logic        o_done,
   output logic [7:0]  o_beat_index,
   output logic [15:0] o_score,
   output logic [7:0]  o_streak
);

   localparam int             CIW      = (COUNTIN_BEATS > 1) ? $clog2(COUNTIN_BEATS) : 1;
   localparam logic [CIW-1:0] CIN_LAST = CIW'(COUNTIN_BEATS - 1);
   localparam logic [7:0]     BI_LAST  = 8'(SONG_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COUNTIN = 3'd2,
      ST_PLAY    = 3'd3,
      ST_PAUSE   = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t         r_state;
   state_t         w_next;
   state_t         r_ret;

   logic           r_load_ph;
   logic           r_first;
   logic           r_rst_d;
   logic           r_beat;
   logic           r_song_id;
   logic [25:0]    r_tempo_q;
   logic [25:0]    r_cnt;
   logic [25:0]    w_period;
   logic [25:0]    w_last;
   logic [CIW-1:0] r_cin;
   logic [7:0]     r_beat_index;
   logic [7:0]     r_streak;
   logic [15:0]    r_score;

   logic           w_run;
   logic           w_match;
   logic           w_beat_evt;
   logic           w_end;
   logic           w_start_go;
   logic           w_pause_go;

   assign w_run    = (r_state == ST_COUNTIN) || (r_state == ST_PLAY);
   // tempo_q is only written at the end of the first count-in cycle, so that
   // cycle compares against the live input (matters when the period is 1).
   assign w_period = r_first ? i_tempo : r_tempo_q;
   assign w_last   = (w_period == 26'd0) ? 26'd0 : (w_period - 26'd1);
   assign w_match  = w_run && (r_cnt == w_last);
   // stop and pause both outrank the beat; a suppressed match keeps the counter parked.
   assign w_beat_evt = w_match && !i_stop && !i_pause;
   assign w_end      = (i_hit_note == END_NOTE) || (r_beat_index == BI_LAST);
   assign w_start_go = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start && !i_stop;
   assign w_pause_go = w_run && i_pause && !i_stop;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (i_stop && (r_state != ST_IDLE)) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
               if (r_load_ph) w_next = ST_COUNTIN;
            end
            ST_COUNTIN: begin
               if (i_pause)                              w_next = ST_PAUSE;
               else if (w_beat_evt && (r_cin == CIN_LAST)) w_next = ST_PLAY;
            end
            ST_PLAY: begin
               if (i_pause)                  w_next = ST_PAUSE;
               else if (w_beat_evt && w_end) w_next = ST_DONE;
            end
            ST_PAUSE: begin
               if (i_pause) w_next = r_ret;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge i_clk) begin
      // Stretches loader_reset over the cycle following reset release.
      r_rst_d <= i_reset;
      if (i_reset) begin
         r_ret        <= ST_COUNTIN;
         r_load_ph    <= 1'b0;
         r_first      <= 1'b0;
         r_beat       <= 1'b0;
         r_song_id    <= 1'b0;
         r_tempo_q    <= 26'd0;
         r_cnt        <= 26'd0;
         r_cin        <= '0;
         r_beat_index <= 8'd0;
         r_streak     <= 8'd0;
         r_score      <= 16'd0;
      end else begin
         r_beat    <= w_beat_evt;
         r_load_ph <= (r_state == ST_LOAD) ? ~r_load_ph : 1'b0;
         r_first   <= (r_state == ST_LOAD) && (w_next == ST_COUNTIN);

         if (r_first) r_tempo_q <= i_tempo;

         if (r_state == ST_LOAD) begin
            r_cnt <= 26'd0;
         end else if (w_run && !i_stop && !i_pause) begin
            r_cnt <= w_match ? 26'd0 : (r_cnt + 26'd1);
         end

         if (w_pause_go) r_ret <= r_state;

         if (w_start_go) begin
            r_song_id    <= i_song_sel;
            r_score      <= 16'd0;
            r_streak     <= 8'd0;
            r_beat_index <= 8'd0;
            r_cin        <= '0;
         end

         if (w_beat_evt && (r_state == ST_COUNTIN)) r_cin <= r_cin + 1'b1;

         // Terminating beats (end note or last slot) are never scored.
         if (w_beat_evt && (r_state == ST_PLAY) && !w_end) begin
            r_beat_index <= r_beat_index + 8'd1;
            if (i_hit_note != 4'd0) begin
               if (i_player_valid && (i_player_note == i_hit_note)) begin
                  if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
                  if (r_streak != 8'hFF)   r_streak <= r_streak + 8'd1;
               end else begin
                  r_streak <= 8'd0;
               end
            end
         end
      end
   end

   // ---------------- Outputs ----------------
   assign o_loader_reset = i_reset | r_rst_d | (r_state == ST_LOAD);
   assign o_song_id      = r_song_id;
   assign o_beat         = r_beat;
   assign o_playing      = w_run;
   assign o_paused       = (r_state == ST_PAUSE);
   assign o_done         = (r_state == ST_DONE);
   assign o_beat_index   = r_beat_index;
   assign o_score        = r_score;
   assign o_streak       = r_streak;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: song-level stimulus with an arithmetic beat-time and
// scoring model; expected beats are queued and checked by an independent monitor.
module tb_song_sequencer;

   localparam int CB = 2;
   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        i_reset, i_start, i_pause, i_stop, i_song_sel, i_player_valid;
   logic [25:0] i_tempo;
   logic [3:0]  i_hit_note, i_player_note;
   logic        o_loader_reset, o_song_id, o_beat, o_playing, o_paused, o_done;
   logic [7:0]  o_beat_index, o_streak;
   logic [15:0] o_score;

   always #5 clk = ~clk;

   song_sequencer #(.COUNTIN_BEATS(CB), .SONG_LEN(SL), .END_NOTE(4'hF)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_pause(i_pause),
      .i_stop(i_stop), .i_song_sel(i_song_sel), .i_tempo(i_tempo),
      .i_hit_note(i_hit_note), .i_player_note(i_player_note),
      .i_player_valid(i_player_valid), .o_loader_reset(o_loader_reset),
      .o_song_id(o_song_id), .o_beat(o_beat), .o_playing(o_playing),
      .o_paused(o_paused), .o_done(o_done), .o_beat_index(o_beat_index),
      .o_score(o_score), .o_streak(o_streak)
   );

   typedef struct {
      int cyc;
      int score;
      int streak;
      int bi;
      int done;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   g_hit[8];
   int   g_pn[8];
   int   g_pv[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: every beat pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
         n_chk++;
         n_err++;
         $display("FAIL beat_missing at cycle %0d: no beat seen, expected at cycle %0d", cyc, q[0].cyc);
         void'(q.pop_front());
      end
      if (o_beat === 1'b1) begin
         if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL beat_unexpected at cycle %0d: beat=1, expected 0", cyc);
         end else begin
            e = q.pop_front();
            chk("beat_cycle",  32'(cyc),          32'(e.cyc));
            chk("beat_score",  32'(o_score),      32'(e.score));
            chk("beat_streak", 32'(o_streak),     32'(e.streak));
            chk("beat_index",  32'(o_beat_index), 32'(e.bi));
            chk("beat_done",   32'(o_done),       32'(e.done));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic start_song(input int t, input bit sel, output int s);
      s          = cyc;
      i_start    = 1'b1;
      i_song_sel = sel;
      i_tempo    = 26'(t);
      tick();
      i_start = 1'b0;
      chk("ldrst_load1", 32'(o_loader_reset), 32'd1);
      tick();
      chk("ldrst_load2", 32'(o_loader_reset), 32'd1);
      tick();
      chk("ldrst_off",    32'(o_loader_reset), 32'd0);
      chk("countin_play", 32'(o_playing),      32'd1);
      chk("song_id",      32'(o_song_id),      32'(sel));
      chk("start_score",  32'(o_score),        32'd0);
      chk("start_bi",     32'(o_beat_index),   32'd0);
   endtask

   task automatic run_song(input int t, input bit sel, input int pause_at, input int stop_at);
      int s, te, pulse, m, sc, st, bi;
      bit term;
      sc = 0; st = 0; bi = 0;
      start_song(t, sel, s);
      te    = (t == 0) ? 1 : t;
      pulse = s + 3 + te;
      for (int k = 0; k < CB; k++) begin
         q.push_back('{pulse, 0, 0, 0, 0});
         wait_until(pulse);
         if (k == 0) i_tempo = 26'($urandom_range(1, 60));
         pulse += te;
      end
      for (int j = 0; j < 8; j++) begin
         i_hit_note     = 4'(g_hit[j]);
         i_player_note  = 4'(g_pn[j]);
         i_player_valid = g_pv[j][0];
         term = (g_hit[j] == 15) || (bi == SL - 1);
         if (!term) begin
            if (g_hit[j] != 0) begin
               if (g_pv[j] != 0 && g_pn[j] == g_hit[j]) begin
                  if (sc < 65535) sc++;
                  if (st < 255) st++;
               end else begin
                  st = 0;
               end
            end
            bi++;
         end
         if (j == pause_at) begin
            m = pulse - 1;
            wait_until(m);
            i_pause = 1'b1;
            tick();
            i_pause = 1'b0;
            wait_until(m + 10);
            chk("pause_paused",  32'(o_paused),  32'd1);
            chk("pause_playing", 32'(o_playing), 32'd0);
            if (j == stop_at) begin
               i_stop = 1'b1;
               tick();
               i_stop = 1'b0;
               chk("stop_paused",  32'(o_paused),     32'd0);
               chk("stop_playing", 32'(o_playing),    32'd0);
               chk("stop_done",    32'(o_done),       32'd0);
               chk("stop_score",   32'(o_score),      32'(sc - ((term || g_hit[j] == 0 || !(g_pv[j] != 0 && g_pn[j] == g_hit[j])) ? 0 : 1)));
               chk("stop_bi",      32'(o_beat_index), 32'(term ? bi : bi - 1));
               return;
            end
            wait_until(m + 21);
            i_pause = 1'b1;
            tick();
            i_pause = 1'b0;
            pulse = m + 23;
         end
         q.push_back('{pulse, sc, st, bi, int'(term)});
         wait_until(pulse);
         if (term) begin
            chk("end_done",    32'(o_done),    32'd1);
            chk("end_playing", 32'(o_playing), 32'd0);
            return;
         end
         pulse += te;
      end
   endtask

   task automatic fill_random();
      int r;
      for (int i = 0; i < 8; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)     g_hit[i] = 15;
         else if (r < 3) g_hit[i] = 0;
         else            g_hit[i] = $urandom_range(1, 14);
         g_pv[i] = ($urandom_range(0, 4) != 0) ? 1 : 0;
         g_pn[i] = ($urandom_range(0, 2) != 0) ? g_hit[i] : $urandom_range(0, 15);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog at cycle %0d: bench did not finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, pa, sa;
      i_reset = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
      i_song_sel = 1'b0; i_tempo = 26'd4; i_hit_note = 4'd0;
      i_player_note = 4'd0; i_player_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin g_hit[i] = 0; g_pn[i] = 0; g_pv[i] = 0; end

      wait_until(3);
      chk("rst_ldrst",   32'(o_loader_reset), 32'd1);
      chk("rst_outputs", {22'd0, o_song_id, o_beat, o_playing, o_paused, o_done, 5'd0}, 32'd0);
      chk("rst_score",   32'(o_score), 32'd0);
      chk("rst_counts",  {16'd0, o_beat_index, o_streak}, 32'd0);
      wait_until(4);
      i_reset = 1'b0;
      chk("rst_after_ldrst", 32'(o_loader_reset), 32'd1);
      tick();
      chk("rst_ldrst_clear", 32'(o_loader_reset), 32'd0);

      // Directed: tempo 4 from cycle 10; 3 scored beats then the SONG_LEN limit.
      g_hit[0] = 5; g_hit[1] = 5; g_hit[2] = 5; g_hit[3] = 7;
      g_pn[0]  = 5; g_pn[1]  = 5; g_pn[2]  = 3; g_pn[3]  = 7;
      for (int i = 0; i < 4; i++) g_pv[i] = 1;
      wait_until(10);
      run_song(4, 1'b1, -1, -1);

      // Directed: tempo 0 (period 1), pause on a rest beat, then end note.
      g_hit[0] = 4; g_hit[1] = 0; g_hit[2] = 15;
      g_pn[0]  = 4; g_pn[1]  = 0; g_pn[2]  = 0;
      repeat (3) tick();
      run_song(0, 1'b0, 1, -1);

      for (int n = 0; n < 6; n++) begin
         fill_random();
         pa = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 3);
         sa = ($urandom_range(0, 3) == 0) ? pa : -1;
         repeat ($urandom_range(1, 4)) tick();
         run_song($urandom_range(0, 5), 1'($urandom_range(0, 1)), pa, sa);
      end

      // Directed: one correct note, pause, stop while paused.
      g_hit[0] = 6; g_hit[1] = 6;
      g_pn[0]  = 6; g_pn[1]  = 0;
      g_pv[0]  = 1; g_pv[1]  = 1;
      repeat (2) tick();
      run_song(3, 1'b1, 1, 1);
      chk("held_score", 32'(o_score), 32'd1);

      i_reset = 1'b1;
      tick();
      chk("reset_score",   32'(o_score),   32'd0);
      chk("reset_song_id", 32'(o_song_id), 32'd0);
      chk("reset_streak",  32'(o_streak),  32'd0);
      i_reset = 1'b0;
      tick();

      // Mid-count-in reset clears the latched song and stops the game.
      start_song(5, 1'b1, s);
      repeat (2) tick();
      i_reset = 1'b1;
      tick();
      chk("midrst_playing", 32'(o_playing),      32'd0);
      chk("midrst_song_id", 32'(o_song_id),      32'd0);
      chk("midrst_ldrst",   32'(o_loader_reset), 32'd1);
      i_reset = 1'b0;
      repeat (20) tick();
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
